// File: rtl/cnn_mac_pipe_if.sv
// cnn_mac_pipe_if: tap-in / window-sum-out handshake bundle for cnn_mac_pipe.
//   in_valid/in_ready/din0/din1      : tap stream into the MAC (din0 unsigned, din1 signed)
//   out_valid/out_ready/dout/out_ovf : completed window sums out of the MAC
// master = upstream/downstream side, slave = the MAC itself.
interface cnn_mac_pipe_if #(
  parameter int unsigned DIN0_WIDTH = 17,
  parameter int unsigned DIN1_WIDTH = 18,
  parameter int unsigned ACC_WIDTH  = 40
);
  logic                         in_valid;
  logic                         in_ready;
  logic [DIN0_WIDTH-1:0]        din0;
  logic signed [DIN1_WIDTH-1:0] din1;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [ACC_WIDTH-1:0]  dout;
  logic                         out_ovf;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, out_ovf
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, out_ovf
  );
endinterface

// File: rtl/cnn_mac_pipe.sv
// cnn_mac_pipe: pipelined unsigned x signed multiply-accumulate for the Conv1D datapath.
// Each accepted tap's exact product travels through NUM_STAGE registers, then is summed into
// a window accumulator; every TAP_COUNT taps one signed window sum is presented on dout.
// Ports:
//   ap_clk  : clock, rising edge
//   ap_rst  : synchronous active-high reset (discards any partial window)
//   mac_io  : cnn_mac_pipe_if.slave (tap stream in, window sums out, out_ovf flag)
// Build option: define CNN_MAC_SAT_EN for saturating accumulation with a sticky per-window
// overflow flag on out_ovf; otherwise accumulation wraps and out_ovf stays 0.
module cnn_mac_pipe #(
  parameter int unsigned DIN0_WIDTH = 17,
  parameter int unsigned DIN1_WIDTH = 18,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned TAP_COUNT  = 12
) (
  input logic           ap_clk,
  input logic           ap_rst,
  cnn_mac_pipe_if.slave mac_io
);
  localparam int unsigned ProdW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int unsigned CntW  = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TAP_COUNT - 1);

  logic                              stall;
  logic                              accept;
  logic signed [ProdW-1:0]           op0;
  logic signed [ProdW-1:0]           op1;
  logic signed [ProdW-1:0]           prod_in;
  logic [CntW-1:0]                   cnt_q, cnt_d;
  logic [NUM_STAGE-1:0]              vld_q, vld_d;
  logic [NUM_STAGE-1:0]              last_q, last_d;
  logic [NUM_STAGE-1:0][ProdW-1:0]   prod_q, prod_d;
  logic signed [ACC_WIDTH-1:0]       acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]       dout_q, dout_d;
  logic                              out_valid_q, out_valid_d;
  logic                              ovf_q, ovf_d;
  logic                              out_ovf_q, out_ovf_d;
  logic signed [ACC_WIDTH-1:0]       prod_ext;
  logic signed [ACC_WIDTH-1:0]       sum;
  logic                              clip;

  // A held result blocks the whole pipeline so no tap is lost or duplicated.
  assign stall  = out_valid_q & ~mac_io.out_ready;
  assign accept = mac_io.in_valid & ~stall;

  // Zero-extended activation times sign-extended weight; exact in ProdW bits.
  assign op0     = ProdW'($signed({1'b0, mac_io.din0}));
  assign op1     = ProdW'(mac_io.din1);
  assign prod_in = op0 * op1;

  assign prod_ext = ACC_WIDTH'($signed(prod_q[NUM_STAGE-1]));

`ifdef CNN_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic [ACC_WIDTH:0] wide_sum;

  always_comb begin
    wide_sum = {acc_q[ACC_WIDTH-1], acc_q} + {prod_ext[ACC_WIDTH-1], prod_ext};
    // Top two bits disagree only when the true sum left the signed range.
    clip     = wide_sum[ACC_WIDTH] ^ wide_sum[ACC_WIDTH-1];
    if (clip) begin
      sum = wide_sum[ACC_WIDTH] ? AccMin : AccMax;
    end else begin
      sum = wide_sum[ACC_WIDTH-1:0];
    end
  end
`else
  always_comb begin
    sum  = acc_q + prod_ext;
    clip = 1'b0;
  end
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
    end

    vld_d     = vld_q;
    last_d    = last_q;
    prod_d    = prod_q;
    vld_d[0]  = accept;
    last_d[0] = accept && (cnt_q == LastCnt);
    prod_d[0] = prod_in;
    for (int i = 1; i < NUM_STAGE; i++) begin
      vld_d[i]  = vld_q[i-1];
      last_d[i] = last_q[i-1];
      prod_d[i] = prod_q[i-1];
    end
  end

  always_comb begin
    acc_d       = acc_q;
    dout_d      = dout_q;
    ovf_d       = ovf_q;
    out_ovf_d   = out_ovf_q;
    // Registers only load when not stalled, so any presented result has just been taken.
    out_valid_d = 1'b0;
    if (vld_q[NUM_STAGE-1]) begin
      if (last_q[NUM_STAGE-1]) begin
        dout_d      = sum;
        out_valid_d = 1'b1;
        out_ovf_d   = ovf_q | clip;
        acc_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = sum;
        ovf_d = ovf_q | clip;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt_q       <= '0;
      vld_q       <= '0;
      last_q      <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else if (!stall) begin
      cnt_q       <= cnt_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign mac_io.in_ready  = ~stall;
  assign mac_io.out_valid = out_valid_q;
  assign mac_io.dout      = dout_q;
  assign mac_io.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Bench for cnn_mac_pipe: three instances (defaults, TAP_COUNT=1, ACC_WIDTH=36).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_cnn_mac_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_mac_pipe_if #(.DIN0_WIDTH(17), .DIN1_WIDTH(18), .ACC_WIDTH(40)) ia ();
  cnn_mac_pipe_if #(.DIN0_WIDTH(17), .DIN1_WIDTH(18), .ACC_WIDTH(40)) ib ();
  cnn_mac_pipe_if #(.DIN0_WIDTH(17), .DIN1_WIDTH(18), .ACC_WIDTH(36)) ic ();

  cnn_mac_pipe #(.TAP_COUNT(12)) u_a (.ap_clk(clk), .ap_rst(rst), .mac_io(ia));
  cnn_mac_pipe #(.TAP_COUNT(1))  u_b (.ap_clk(clk), .ap_rst(rst), .mac_io(ib));
  cnn_mac_pipe #(.ACC_WIDTH(36)) u_c (.ap_clk(clk), .ap_rst(rst), .mac_io(ic));

`ifdef CNN_MAC_SAT_EN
  localparam longint T6Dout = 64'sd34359738367;
  localparam longint T6Ovf  = 1;
`else
  localparam longint T6Dout = -64'sd3145716;
  localparam longint T6Ovf  = 0;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic bit rdy(input int sel);
    case (sel)
      0:       return ia.in_ready;
      1:       return ib.in_ready;
      default: return ic.in_ready;
    endcase
  endfunction

  function automatic bit ovld(input int sel);
    case (sel)
      0:       return ia.out_valid;
      1:       return ib.out_valid;
      default: return ic.out_valid;
    endcase
  endfunction

  task automatic drive(input int sel, input bit v, input longint a, input longint b);
    case (sel)
      0:       begin ia.in_valid = v; ia.din0 = 17'(a); ia.din1 = 18'(b); end
      1:       begin ib.in_valid = v; ib.din0 = 17'(a); ib.din1 = 18'(b); end
      default: begin ic.in_valid = v; ic.din0 = 17'(a); ic.din1 = 18'(b); end
    endcase
  endtask

  // Present one tap and return once it has been accepted (cycles = edges spent).
  task automatic send(input int sel, input longint a, input longint b, output int cycles);
    bit ok;
    ok     = 1'b0;
    cycles = 0;
    drive(sel, 1'b1, a, b);
    while (!ok) begin
      @(negedge clk);
      ok = rdy(sel);
      @(posedge clk);
      #1;
      cycles++;
      if (!ok && cycles > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic idle(input int sel);
    drive(sel, 1'b0, 0, 0);
  endtask

  // Returns on the falling edge where out_valid is first seen.
  task automatic wait_out(input int sel);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ovld(sel)) return;
    end
    chk("wait_out_timeout", 0, 1);
  endtask

  task automatic resync();
    @(posedge clk);
    #1;
  endtask

  // Reference model for instance A: window sums of accepted taps, compared at each transfer.
  longint sb_exp[$];
  longint sb_sum   = 0;
  int     sb_n     = 0;
  int     acc_taps = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_exp.delete();
        sb_sum = 0;
        sb_n   = 0;
      end else begin
        if (ia.out_valid && ia.out_ready) begin
          if (sb_exp.size() == 0) chk("sb_unexpected_out", 1, 0);
          else chk("sb_window", longint'(ia.dout), sb_exp.pop_front());
        end
        if (ia.in_valid && ia.in_ready) begin
          acc_taps++;
          sb_sum += longint'(ia.din0) * longint'(ia.din1);
          sb_n++;
          if (sb_n == 12) begin
            sb_exp.push_back(sb_sum);
            sb_sum = 0;
            sb_n   = 0;
          end
        end
      end
    end
  end

  typedef struct {
    longint a;
    longint b;
    longint exp_dout;
    longint exp_ovf;
  } vec_t;

  vec_t   vecs[5];
  int     w;
  int     wsum;
  int     early;
  int     bad_rdy;
  int     bad_hold;
  int     taps0;
  bit     rand_done;

  initial begin
    vecs[0] = '{a: 131071, b: -131072, exp_dout: -64'sd17179738112, exp_ovf: 0};
    vecs[1] = '{a: 0,      b: 5,       exp_dout: 0,                 exp_ovf: 0};
    vecs[2] = '{a: 1,      b: -1,      exp_dout: -1,                exp_ovf: 0};
    vecs[3] = '{a: 131071, b: 131071,  exp_dout: 64'sd17179607041,  exp_ovf: 0};
    vecs[4] = '{a: 100,    b: -3,      exp_dout: -300,              exp_ovf: 0};

    rst = 1'b1;
    idle(0); idle(1); idle(2);
    ia.out_ready = 1'b1; ib.out_ready = 1'b1; ic.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_out_valid", longint'(ia.out_valid), 0);
    chk("rst_dout", longint'(ia.dout), 0);
    chk("rst_in_ready", longint'(ia.in_ready), 1);
    chk("rst_out_ovf", longint'(ia.out_ovf), 0);
    resync();

    // Test 1: back-to-back window, latency and single-pulse output.
    wsum = 0;
    for (int i = 1; i <= 12; i++) begin
      send(0, i, 2, w);
      wsum += w;
    end
    idle(0);
    chk("t1_in_ready_cycles", wsum, 12);
    early = 0;
    repeat (3) begin
      @(negedge clk);
      early += int'(ia.out_valid);
      resync();
    end
    chk("t1_early_valid", early, 0);
    @(negedge clk);
    chk("t1_valid", longint'(ia.out_valid), 1);
    chk("t1_dout", longint'(ia.dout), 156);
    chk("t1_ovf", longint'(ia.out_ovf), 0);
    resync();
    @(negedge clk);
    chk("t1_pulse", longint'(ia.out_valid), 0);
    resync();

    // Test 3: stall while the next window streams.
    taps0 = acc_taps;
    for (int i = 1; i <= 12; i++) send(0, i, 2, w);
    ia.out_ready = 1'b0;
    bad_rdy  = 0;
    bad_hold = 0;
    fork
      begin
        for (int i = 1; i <= 12; i++) send(0, i, 2, w);
        idle(0);
      end
      begin
        wait_out(0);
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          if (ia.in_ready) bad_rdy++;
          if (!ia.out_valid || ia.dout != 40'sd156) bad_hold++;
          resync();
        end
        ia.out_ready = 1'b1;
      end
    join
    chk("t3_stall_in_ready", bad_rdy, 0);
    chk("t3_stall_hold", bad_hold, 0);
    wait_out(0);
    chk("t3_dout2", longint'(ia.dout), 156);
    chk("t3_taps", acc_taps - taps0, 24);
    resync();

    // Test 4: bubble between every tap.
    for (int i = 1; i <= 12; i++) begin
      send(0, i, 2, w);
      idle(0);
      resync();
    end
    wait_out(0);
    chk("t4_dout", longint'(ia.dout), 156);
    resync();

    // Test 5: reset mid-window discards the partial sum.
    for (int i = 1; i <= 5; i++) send(0, i, 2, w);
    idle(0);
    rst = 1'b1;
    resync();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_out_valid", longint'(ia.out_valid), 0);
    chk("t5_dout", longint'(ia.dout), 0);
    chk("t5_in_ready", longint'(ia.in_ready), 1);
    resync();
    for (int i = 1; i <= 12; i++) send(0, i, 2, w);
    idle(0);
    wait_out(0);
    chk("t5_dout_after", longint'(ia.dout), 156);
    resync();

    // Test 2: single-tap windows from the vector table.
    for (int i = 0; i < 5; i++) begin
      send(1, vecs[i].a, vecs[i].b, w);
      idle(1);
      wait_out(1);
      chk($sformatf("t2_dout[%0d]", i), longint'(ib.dout), vecs[i].exp_dout);
      chk($sformatf("t2_ovf[%0d]", i), longint'(ib.out_ovf), vecs[i].exp_ovf);
      resync();
    end

    // Test 6: 36-bit accumulator overflow, then a clean window clears the flag.
    for (int i = 0; i < 12; i++) send(2, 131071, 131071, w);
    idle(2);
    wait_out(2);
    chk("t6_dout", longint'(ic.dout), T6Dout);
    chk("t6_ovf", longint'(ic.out_ovf), T6Ovf);
    resync();
    for (int i = 0; i < 12; i++) send(2, 1, 1, w);
    idle(2);
    wait_out(2);
    chk("t6_dout_clean", longint'(ic.dout), 12);
    chk("t6_ovf_clean", longint'(ic.out_ovf), 0);
    resync();

    // Random taps, bubbles and backpressure against the window model.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 240; i++) begin
          longint a;
          longint b;
          if ($urandom_range(3) == 0) begin
            idle(0);
            resync();
          end
          a = ($urandom_range(7) == 0) ? 131071 : longint'($urandom_range(131071));
          b = ($urandom_range(7) == 0) ? -131072 : longint'($urandom_range(262143)) - 131072;
          send(0, a, b, w);
        end
        idle(0);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          resync();
          ia.out_ready = ($urandom_range(3) != 0);
        end
      end
    join
    ia.out_ready = 1'b1;
    repeat (20) resync();
    chk("rand_drained", sb_exp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/cnn_mac_pipe.md
Name: cnn_mac_pipe

Overview:
- Parametrised, pipelined multiply-accumulate unit for the Conv1D datapath.
- Multiplies an unsigned activation by a signed weight and accumulates TAP_COUNT products per output sample.
- Emits one result per kernel window over a valid/ready handshake.
- Supersedes the single-cycle combinational unsigned×signed multiplier in the convolution engine.

Parameters:
- DIN0_WIDTH, 17, activation width (unsigned)
- DIN1_WIDTH, 18, weight width (signed, two's complement)
- NUM_STAGE, 3, product pipeline register stages, ≥1
- ACC_WIDTH, 40, accumulator/result width (signed), ≥ DIN0_WIDTH+DIN1_WIDTH
- TAP_COUNT, 12, products accumulated per window, ≥1

Ports:
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst  in  1  synchronous, active-high reset
- in_valid  in  1  din0/din1 hold a tap
- in_ready  out  1  block accepts a tap this cycle
- din0  in  DIN0_WIDTH  unsigned activation
- din1  in  DIN1_WIDTH  signed weight
- out_valid  out  1  dout holds a completed window sum
- out_ready  in  1  downstream accepts dout
- dout  out  ACC_WIDTH  signed window sum
- out_ovf  out  1  overflow flag for current dout (see Optional Feature)

Behaviour:
- Product: p = signed({1'b0,din0}) × signed(din1), width DIN0_WIDTH+DIN1_WIDTH, exact. Sign-extended to ACC_WIDTH before accumulation.
- Handshake:
  - A tap is accepted on a rising edge with in_valid && in_ready.
  - Output transfer occurs on an edge with out_valid && out_ready.
- Global stall: stall = out_valid && !out_ready; in_ready = !stall.
  - During stall, every pipeline stage, the tap counter, the accumulator, dout and out_ovf hold.
- Pipeline:
  - Each tap carries a valid bit and a last flag through NUM_STAGE registers.
  - Bubbles (in_valid=0) propagate as invalid stages and do not touch the accumulator.
- Tap counter:
  - 0..TAP_COUNT-1, increments per accepted tap.
  - The tap accepted at count TAP_COUNT-1 is tagged last; the counter wraps to 0.
- Accumulate stage, when a valid product leaves stage NUM_STAGE:
  - Not last: acc <= acc + p.
  - Last: dout <= acc + p, out_valid <= 1, acc <= 0.
  - TAP_COUNT=1: dout = p.
- Latency: tap accepted on edge E0 → its contribution reaches dout on edge E(NUM_STAGE). out_valid is visible after edge E(NUM_STAGE), with no stalls in between.
- out_valid clears on an output transfer edge unless a new last product completes on that same edge, in which case dout reloads and out_valid stays 1.
- Throughput: 1 tap/cycle sustained when out_ready=1. No tap is ever dropped or duplicated.
- Reset (ap_rst=1 at an edge), including mid-window:
  - out_valid=0, dout=0, out_ovf=0, acc=0, tap counter=0.
  - All pipeline valid bits 0; partial window discarded.
  - in_ready=1 in the cycle after reset.

Optional Feature:
- Macro: CNN_MAC_SAT_EN.
- Defined:
  - Each accumulate is saturating to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - A per-window sticky overflow bit is set on any clip.
  - The bit is copied to out_ovf with dout and cleared at window start.
- Undefined:
  - Accumulation wraps modulo 2^ACC_WIDTH.
  - out_ovf is tied to 0.

Test Plan:
1. Defaults; din0=1..12, din1=2 on consecutive cycles, out_ready=1 → one out_valid pulse with dout=156, 3 edges after the 12th acceptance; in_ready stays 1.
2. TAP_COUNT=1; din0=131071, din1=-131072 → dout=-17179738112 sign-extended to 40 bits, out_ovf=0.
3. Window of test 1, then out_ready=0 for 5 cycles while the next window streams → in_ready=0 during stall, dout holds 156; after release the second window yields 156; total taps accepted = 24.
4. in_valid toggling every other cycle with the test-1 data → dout=156; bubbles do not alter acc.
5. ap_rst pulsed after 5 accepted taps → out_valid=0, dout=0; next full test-1 window yields 156, not 156+partial.
6. ACC_WIDTH=36; 12 taps of din0=131071, din1=131071:
   - With CNN_MAC_SAT_EN: dout=34359738367, out_ovf=1.
   - Without it: dout=-3145716, out_ovf=0.
